axi4_lite_ram_slave: RTL and testbench
======================================

AXI4_LITE_RAM_SLAVE -- requirements
Module: axi4_lite_ram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, byte-address width of awaddr/araddr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width (legal values 32 or 64); STRB_WIDTH = DATA_WIDTH/8, derived.
REQ-003 SHALL have parameter DEPTH, default 16, number of DATA_WIDTH words stored (1..2^(ADDR_WIDTH-log2(STRB_WIDTH))).
REQ-004 SHALL have ports:
  aclk  in  1  clock, all logic on rising edge
  areset  in  1  synchronous active-high reset
  awvalid in 1; awready out 1; awaddr in ADDR_WIDTH; awprot in 3  write address channel
  wvalid in 1; wready out 1; wdata in DATA_WIDTH; wstrb in STRB_WIDTH  write data channel
  bvalid out 1; bready in 1; bresp out 2  write response channel
  arvalid in 1; arready out 1; araddr in ADDR_WIDTH; arprot in 3  read address channel
  rvalid out 1; rready in 1; rdata out DATA_WIDTH; rresp out 2  read data channel
REQ-005 SHALL use one clock (aclk) and a synchronous, active-high reset (areset).

Function
REQ-006 SHALL compute word index = addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]; low byte-offset bits ignored; awprot/arprot ignored.
REQ-007 SHALL run write FSM states W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
REQ-008 SHALL drive awready=1 in W_IDLE/W_HAVE_D, wready=1 in W_IDLE/W_HAVE_W... specifically wready=1 in W_IDLE/W_HAVE_A; both 0 in W_RESP.
REQ-009 SHALL, in W_IDLE: AW+W handshakes same cycle -> W_RESP; AW only -> W_HAVE_A (address buffered); W only -> W_HAVE_D (data+strobe buffered).
REQ-010 SHALL go W_HAVE_A->W_RESP on W handshake and W_HAVE_D->W_RESP on AW handshake.
REQ-011 SHALL commit the write at the edge entering W_RESP: only bytes with wstrb[i]=1 updated; wstrb=0 updates nothing but still responds OKAY.
REQ-012 SHALL assert bvalid only in W_RESP (1 cycle after final handshake), holding bvalid/bresp stable until bready; W_RESP->W_IDLE on bready.
REQ-013 SHALL return bresp OKAY(00) for index<DEPTH; DECERR(11) and no memory change for index>=DEPTH.
REQ-014 SHALL run read FSM states R_IDLE, R_RESP; arready=1 only in R_IDLE; AR handshake -> R_RESP; R_RESP->R_IDLE on rready.
REQ-015 SHALL capture rdata/rresp at the AR handshake edge and assert rvalid the next cycle, holding rdata/rresp stable until rready.
REQ-016 SHALL return rresp DECERR(11), rdata 0 for index>=DEPTH; otherwise OKAY(00) with stored word (subject to REQ-021).
REQ-017 SHALL, when a write commit and AR handshake hit the same index in the same cycle, return the post-merge word (write-first bypass).
REQ-018 SHALL operate read and write channels fully independently; either may stall without affecting the other.
REQ-019 SHALL hold AW/W ready low while the master keeps bready low (no response overrun).

Reset
REQ-020 SHALL, on areset=1 at a rising edge: both FSMs to idle; bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0; all memory words 0; all written flags 0; in-flight transactions discarded, no response issued.

Configuration
REQ-021 SHALL, with AXI4L_WRITTEN_FLAG_EN defined, keep one written flag per word (set by any in-range write commit, incl. wstrb=0) and answer reads of unwritten in-range words with rdata 0, rresp SLVERR(10); without the macro, no flags exist and such reads return stored data (0 after reset) with OKAY.

Structure
REQ-022 SHALL take response codes (OKAY/EXOKAY/SLVERR/DECERR) and write/read FSM state encodings from shared package axi4_lite_pkg.
REQ-023 SHALL place storage and byte-strobe merge in sub-module axi4_lite_ram_array (one write port with byte enables, one read port with write-first bypass).

Verification
REQ-024 SHALL pass: AW addr 0x04 + W data 0xDEADBEEF strb 1111 same cycle -> bvalid next cycle, bresp 00; then AR 0x04 -> rvalid next cycle, rdata 0xDEADBEEF, rresp 00.
REQ-025 SHALL pass: W (0x11223344, strb 0101) three cycles before AW 0x08, word preloaded 0xAABBCCDD -> awready stays 1, wready 0 while waiting; read 0x08 gives 0xAA22CC44.
REQ-026 SHALL pass: bready held 0 for 5 cycles -> bvalid/bresp stable, awready=wready=0; same for rready/rdata with a read.
REQ-027 SHALL pass: AW 0x40 (index 16, DEPTH 16) -> bresp 11, memory unchanged; AR 0x40 -> rresp 11, rdata 0.
REQ-028 SHALL pass: write commit and AR to 0x0C same cycle, data 0x12345678 -> rdata 0x12345678; with AXI4L_WRITTEN_FLAG_EN, read of unwritten 0x10 -> rresp 10, rdata 0.
REQ-029 SHALL pass: areset pulsed while in W_HAVE_A and R_RESP -> next cycle bvalid=rvalid=0, awready=wready=arready=1, all reads return 0.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and FSM state encodings for the RAM slave.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rstate_t;

endpackage

// File: rtl/axi4_lite_ram_array.sv
// Word storage with byte-enable write port and a write-first combinational read port.
module axi4_lite_ram_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  localparam int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic                             hit;

  always_ff @(posedge aclk) begin
    if (areset) begin
      mem <= '0;
    end else if (we) begin
      for (int b = 0; b < STRB_WIDTH; b++)
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign hit = we && (waddr == raddr);

  // Each byte lane forwards the in-flight write so a same-cycle read sees the merged word.
  for (genvar b = 0; b < STRB_WIDTH; b++) begin : g_lane
    assign rdata[8*b +: 8] = (hit && wstrb[b]) ? wdata[8*b +: 8] : mem[raddr][8*b +: 8];
  end

endmodule

// File: rtl/axi4_lite_ram_slave.sv
// AXI4-Lite RAM slave with independent read/write FSMs.
// Optional AXI4L_WRITTEN_FLAG_EN: per-word written flags, unwritten reads answer SLVERR.
module axi4_lite_ram_slave
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [2:0]            awprot,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [2:0]            arprot,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp
);

  localparam int OFF_W  = $clog2(STRB_WIDTH);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  // ---------------- write channel ----------------
  wstate_t               w_state, w_next;
  logic                  aw_hs, w_hs, commit, wr_in_range, wr_en;
  logic [IDX_W-1:0]      aw_idx_q, wr_idx;
  logic [DATA_WIDTH-1:0] wdata_q, wr_data;
  logic [STRB_WIDTH-1:0] wstrb_q, wr_strb;
  resp_t                 bresp_q;

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (awvalid && wvalid) w_next = W_RESP;
        else if (awvalid)      w_next = W_HAVE_A;
        else if (wvalid)       w_next = W_HAVE_D;
      end
      W_HAVE_A: begin
        wready = 1'b1;
        if (wvalid) w_next = W_RESP;
      end
      W_HAVE_D: begin
        awready = 1'b1;
        if (awvalid) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // Final handshake may come from either channel; merge live and buffered halves.
  assign wr_idx      = aw_hs ? awaddr[ADDR_WIDTH-1:OFF_W] : aw_idx_q;
  assign wr_data     = w_hs ? wdata : wdata_q;
  assign wr_strb     = w_hs ? wstrb : wstrb_q;
  assign commit      = (w_state != W_RESP) && (w_next == W_RESP);
  assign wr_in_range = {1'b0, wr_idx} < DEPTH_C;
  assign wr_en       = commit && wr_in_range;
  assign bresp       = bresp_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state  <= W_IDLE;
      bresp_q  <= OKAY;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      w_state <= w_next;
      if (aw_hs) aw_idx_q <= awaddr[ADDR_WIDTH-1:OFF_W];
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (commit) bresp_q <= wr_in_range ? OKAY : DECERR;
    end
  end

  // ---------------- read channel ----------------
  rstate_t               r_state, r_next;
  logic                  ar_hs, rd_in_range, rd_written;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_word, rdata_q;
  resp_t                 rresp_q;

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_next = R_RESP;
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign ar_hs       = arvalid && arready;
  assign rd_idx      = araddr[ADDR_WIDTH-1:OFF_W];
  assign rd_in_range = {1'b0, rd_idx} < DEPTH_C;

`ifdef AXI4L_WRITTEN_FLAG_EN
  logic [DEPTH-1:0] written;

  always_ff @(posedge aclk) begin
    if (areset)     written <= '0;
    else if (wr_en) written[wr_idx[MEM_AW-1:0]] <= 1'b1;
  end

  // A commit landing this cycle counts as written for a same-cycle read.
  assign rd_written = written[rd_idx[MEM_AW-1:0]] || (wr_en && (wr_idx == rd_idx));
`else
  assign rd_written = 1'b1;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        if (!rd_in_range) begin
          rdata_q <= '0;
          rresp_q <= DECERR;
        end else if (!rd_written) begin
          rdata_q <= '0;
          rresp_q <= SLVERR;
        end else begin
          rdata_q <= rd_word;
          rresp_q <= OKAY;
        end
      end
    end
  end

  assign rdata = rdata_q;
  assign rresp = rresp_q;

  axi4_lite_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (MEM_AW)
  ) u_ram (
    .aclk   (aclk),
    .areset (areset),
    .we     (wr_en),
    .waddr  (wr_idx[MEM_AW-1:0]),
    .wdata  (wr_data),
    .wstrb  (wr_strb),
    .raddr  (rd_idx[MEM_AW-1:0]),
    .rdata  (rd_word)
  );

  // Protection bits and byte offsets carry no meaning for this slave.
  logic unused;
  assign unused = ^{awprot, arprot, awaddr[OFF_W-1:0], araddr[OFF_W-1:0]};

endmodule

// File: tb/tb_axi4_lite_ram_slave.sv
// Randomized directed bench for axi4_lite_ram_slave against an array-based memory model.
module tb_axi4_lite_ram_slave;

  logic        aclk = 1'b0;
  logic        areset;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [7:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int tests = 0;
  int fails = 0;

  logic [31:0] mm [16];
  bit          wr [16];

  always #5 aclk = ~aclk;

  axi4_lite_ram_slave dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) begin
      mm[i] = 32'h0;
      wr[i] = 1'b0;
    end
  endfunction

  // {resp, data} a read of byte address a should return
  function automatic logic [33:0] model_rd(input logic [7:0] a);
    int idx;
    idx = int'(a) / 4;
    if (idx >= 16) return {2'b11, 32'h0};
`ifdef AXI4L_WRITTEN_FLAG_EN
    if (!wr[idx]) return {2'b10, 32'h0};
`endif
    return {2'b00, mm[idx]};
  endfunction

  function automatic logic [1:0] model_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a) / 4;
    if (idx >= 16) return 2'b11;
    for (int b = 0; b < 4; b++)
      if (s[b]) mm[idx][8*b +: 8] = d[8*b +: 8];
    wr[idx] = 1'b1;
    return 2'b00;
  endfunction

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int c = 0;
    logic [1:0] eresp;
    awaddr = a; wdata = d; wstrb = s; awprot = 3'($urandom);
    while (!(aw_done && w_done) && c < 64) begin
      awvalid = !aw_done && (c >= aw_dly);
      wvalid  = !w_done && (c >= w_dly);
      if (w_done && !aw_done) chk("wait_aw_ready", {awready, wready}, 2'b10);
      if (aw_done && !w_done) chk("wait_w_ready", {awready, wready}, 2'b01);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick();
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done = 1;
      c++;
    end
    awvalid = 0; wvalid = 0;
    chk("write_handshake_timeout", {aw_done, w_done}, 2'b11);
    eresp = model_wr(a, d, s);
    chk("bvalid", bvalid, 1'b1);
    chk("bresp", bresp, eresp);
    for (int i = 0; i < b_dly; i++) begin
      tick();
      chk("b_hold", {bvalid, bresp, awready, wready}, {1'b1, eresp, 2'b00});
    end
    bready = 1; tick(); bready = 0;
    chk("b_done", {bvalid, awready, wready}, 3'b011);
  endtask

  task automatic axi_read(input logic [7:0] a, input int ar_dly, input int r_dly, output logic [31:0] got);
    logic [33:0] e;
    araddr = a; arprot = 3'($urandom);
    for (int i = 0; i < ar_dly; i++) tick();
    arvalid = 1;
    chk("arready", arready, 1'b1);
    tick();
    arvalid = 0;
    e = model_rd(a);
    got = rdata;
    chk("rvalid", rvalid, 1'b1);
    chk("rdata", rdata, e[31:0]);
    chk("rresp", rresp, e[33:32]);
    for (int i = 0; i < r_dly; i++) begin
      tick();
      chk("r_hold", {rvalid, arready, rresp, rdata}, {1'b1, 1'b0, e});
    end
    rready = 1; tick(); rready = 0;
    chk("r_done", {rvalid, arready}, 2'b01);
  endtask

  initial begin
    logic [31:0] got;
    logic [7:0]  a;
    logic [33:0] e;
    areset = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; awprot = 0; arprot = 0; wdata = 0; wstrb = 0;
    model_clear();
    tick(); tick();
    areset = 0;
    chk("reset_valids", {bvalid, rvalid}, 2'b00);
    chk("reset_readies", {awready, wready, arready}, 3'b111);
    chk("reset_resp_data", {bresp, rresp, rdata}, 36'h0);

    // basic same-cycle write then read back
    axi_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_read(8'h04, 0, 0, got);
    chk("basic_readback", got, 32'hDEADBEEF);

    // data ahead of address, partial strobe over a preloaded word
    axi_write(8'h08, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    axi_write(8'h08, 32'h11223344, 4'b0101, 3, 0, 0);
    axi_read(8'h08, 0, 0, got);
    chk("strobe_merge", got, 32'hAA22CC44);

    // address ahead of data, zero strobe, long response stalls
    axi_write(8'h1B, 32'hCAFEF00D, 4'h0, 0, 2, 5);
    axi_read(8'h18, 1, 5, got);

    // out-of-range address decodes to DECERR and must not alias word 0
    axi_write(8'h00, 32'h0BADC0DE, 4'hF, 0, 0, 0);
    axi_write(8'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_read(8'h40, 0, 0, got);
    axi_read(8'h00, 0, 0, got);
    chk("decerr_no_alias", got, 32'h0BADC0DE);

    // write commit and read to the same word in one cycle; read finishes under a stalled B
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1;
    tick();
    wvalid = 0;
    awaddr = 8'h0C; araddr = 8'h0C; awvalid = 1; arvalid = 1;
    tick();
    awvalid = 0; arvalid = 0;
    void'(model_wr(8'h0C, 32'h12345678, 4'hF));
    chk("bypass_valids", {bvalid, rvalid}, 2'b11);
    chk("bypass_rdata", rdata, 32'h12345678);
    chk("bypass_resps", {bresp, rresp}, 4'b0000);
    rready = 1; tick(); rready = 0;
    chk("indep_r_done", {rvalid, bvalid, arready}, 3'b011);
    bready = 1; tick(); bready = 0;
    chk("indep_b_done", bvalid, 1'b0);

    // never-written in-range word
    axi_read(8'h10, 0, 0, got);

    // random traffic, mostly in range with ignored offset bits
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 71));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(a, $urandom_range(0, 2), $urandom_range(0, 2), got);
    end
    for (int i = 0; i < 16; i++) axi_read(8'(i * 4), 0, 0, got);

    // reset with a write holding its address and a read response pending
    awaddr = 8'h14; awvalid = 1;
    tick();
    awvalid = 0;
    araddr = 8'h04; arvalid = 1;
    tick();
    arvalid = 0;
    chk("pre_reset_state", {bvalid, rvalid, awready, wready, arready}, 5'b01010);
    areset = 1;
    tick();
    areset = 0;
    model_clear();
    chk("midreset_valids", {bvalid, rvalid}, 2'b00);
    chk("midreset_readies", {awready, wready, arready}, 3'b111);
    chk("midreset_resp_data", {bresp, rresp, rdata}, 36'h0);
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom_range(0, 63));
      axi_read(a, 0, 0, got);
      e = model_rd(a);
      chk("post_reset_zero", got, 32'h0);
    end
    axi_write(8'h14, 32'h5A5A5A5A, 4'hF, 2, 0, 0);
    axi_read(8'h14, 0, 0, got);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
